// File: rtl/alu_share_arbiter_if.sv
// Request/response channels between the two ALU requesters and the share arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [3:0]      req0_ctrl;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [3:0]      req1_ctrl;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_result;
  logic            rsp0_err;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_result;
  logic            rsp1_err;

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_err,
    output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_err,
    input  rsp1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one op in flight.
// state | meaning: IDLE accept a request, EXEC drive ALU and capture, RESP hold result until consumed.
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res0_q, res0_d;
  logic [XLEN-1:0] res1_q, res1_d;
  logic            err0_q, err0_d;
  logic            err1_q, err1_d;

  logic grant;
  logic accept;
  logic rsp_hs;
  logic ctrl_legal;

  // Round-robin: on a tie the port that did not win last time goes first.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
  end

  always_comb begin
    ctrl_legal = 1'b0;
    case (ctrl_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
  assign rsp_hs = (state_q == S_RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          ctrl_d       = grant ? bus.req1_ctrl : bus.req0_ctrl;
          a_d          = grant ? bus.req1_a    : bus.req0_a;
          b_d          = grant ? bus.req1_b    : bus.req0_b;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        // Illegal codes still produce whatever the ALU returns; err is flagged alongside.
        if (owner_q) begin
          res1_d = alu_result;
          err1_d = ~ctrl_legal;
        end else begin
          res0_d = alu_result;
          err0_d = ~ctrl_legal;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state_q == S_IDLE) && !grant;
    bus.req1_ready = (state_q == S_IDLE) &&  grant;
    bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
    bus.rsp1_valid = (state_q == S_RESP) &&  owner_q;
    alu_ctrl       = (state_q == S_EXEC) ? ctrl_q : 4'b1111;
    busy           = (state_q != S_IDLE);
  end

  assign bus.rsp0_result = res0_q;
  assign bus.rsp0_err    = err0_q;
  assign bus.rsp1_result = res1_q;
  assign bus.rsp1_err    = err1_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the shared port.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_share_arbiter_if #(.XLEN(XLEN)) bus ();

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU; unknown codes return a recognisable pattern.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = alu_a ^ alu_b ^ 32'hDEAD_0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req0(1'b0, 4'h0, '0, '0);
    set_req1(1'b0, 4'h0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b%b exp 00", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (alu_ctrl !== 4'b1111) begin errors++; $display("FAIL reset_alu_ctrl got %b exp 1111", alu_ctrl); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu_ops got %h %h exp 0 0", alu_a, alu_b); end
    checks++; if (bus.rsp0_result !== '0 || bus.rsp1_result !== '0 || bus.rsp0_err !== 1'b0 || bus.rsp1_err !== 1'b0)
      begin errors++; $display("FAIL reset_rsp_regs got %h %h %b %b exp 0 0 0 0", bus.rsp0_result, bus.rsp1_result, bus.rsp0_err, bus.rsp1_err); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req0(1'b1, 4'b0010, 32'd5, 32'd7);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", bus.req0_ready); end
    tick();
    set_req0(1'b0, 4'h0, '0, '0);
    checks++; if (alu_ctrl !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7)
      begin errors++; $display("FAIL single_exec got %b %h %h exp 0010 5 7", alu_ctrl, alu_a, alu_b); end
    checks++; if (busy !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL single_busy got busy=%b rdy=%b exp 1 0", busy, bus.req0_ready); end
    tick();
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd12 || bus.rsp0_err !== 1'b0)
      begin errors++; $display("FAIL single_rsp got v=%b r=%h e=%b exp 1 c 0", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_quiet got %b exp 0", bus.rsp1_valid); end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    checks++; if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0 || alu_ctrl !== 4'b1111)
      begin errors++; $display("FAIL single_done got v=%b busy=%b ctrl=%b exp 0 0 1111", bus.rsp0_valid, busy, alu_ctrl); end
  endtask

  task automatic test_back_to_back();
    int prev;
    apply_reset();
    set_req0(1'b1, 4'b0110, 32'd10, 32'd3);
    set_req1(1'b1, 4'b0000, 32'h0000_00F0, 32'h0000_003C);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      logic exp_port;
      exp_port = (i % 2 == 1);
      checks++; if (bus.req0_ready !== !exp_port || bus.req1_ready !== exp_port)
        begin errors++; $display("FAIL b2b_grant%0d got %b%b exp port %0d", i, bus.req0_ready, bus.req1_ready, exp_port); end
      if (i > 0) begin
        checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 3", i, cyc - prev); end
      end
      prev = cyc;
      tick();
      tick();
      if (!exp_port) begin
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_result !== 32'd7)
          begin errors++; $display("FAIL b2b_rsp%0d got v=%b%b r=%h exp 10 7", i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_result); end
      end else begin
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_result !== 32'h30)
          begin errors++; $display("FAIL b2b_rsp%0d got v=%b%b r=%h exp 01 30", i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_result); end
      end
      if (i == 3) begin
        set_req0(1'b0, 4'h0, '0, '0);
        set_req1(1'b0, 4'h0, '0, '0);
      end
      tick();
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_illegal_ctrl();
    set_req1(1'b1, 4'b1111, 32'd1, 32'd1);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", bus.req1_ready); end
    tick();
    set_req1(1'b0, 4'h0, '0, '0);
    tick();
    checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_err !== 1'b1 || bus.rsp1_result !== 32'hDEAD_0000)
      begin errors++; $display("FAIL illegal_rsp got v=%b e=%b r=%h exp 1 1 dead0000", bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result); end
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_req0(1'b1, 4'b0010, 32'd2, 32'd3);
    set_req1(1'b1, 4'b0001, 32'd1, 32'd2);
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      begin errors++; $display("FAIL bp_grant got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    tick();
    set_req0(1'b0, 4'h0, '0, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd5 || bus.req1_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got v=%b r=%h rdy1=%b exp 1 5 0", i, bus.rsp0_valid, bus.rsp0_result, bus.req1_ready); end
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_ready got %b exp 0", bus.req1_ready); end
    tick();
    bus.rsp0_ready = 1'b0;
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b1)
      begin errors++; $display("FAIL bp_after_hs got v0=%b rdy1=%b exp 0 1", bus.rsp0_valid, bus.req1_ready); end
    tick();
    set_req1(1'b0, 4'h0, '0, '0);
    checks++; if (alu_ctrl !== 4'b0001) begin errors++; $display("FAIL bp_req1_exec got %b exp 0001", alu_ctrl); end
    tick();
    checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'd3 || bus.rsp1_err !== 1'b0)
      begin errors++; $display("FAIL bp_req1_rsp got v=%b r=%h e=%b exp 1 3 0", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err); end
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    set_req0(1'b1, 4'b0010, 32'd1, 32'd1);
    set_req1(1'b1, 4'b0001, 32'd4, 32'd8);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_grant got %b exp 1", bus.req0_ready); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || alu_ctrl !== 4'b1111)
      begin errors++; $display("FAIL rst_async got busy=%b v=%b%b ctrl=%b exp 0 00 1111", busy, bus.rsp0_valid, bus.rsp1_valid, alu_ctrl); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      begin errors++; $display("FAIL rst_first_grant got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    @(posedge clk);
    #1;
    set_req0(1'b0, 4'h0, '0, '0);
    set_req1(1'b0, 4'h0, '0, '0);
    checks++; if (alu_ctrl !== 4'b0010 || alu_a !== 32'd1) begin errors++; $display("FAIL rst_exec got %b %h exp 0010 1", alu_ctrl, alu_a); end
    tick();
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_result !== 32'd2)
      begin errors++; $display("FAIL rst_rsp got v=%b%b r=%h exp 10 2", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_result); end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_slt_signed();
    set_req0(1'b1, 4'b0111, 32'h8000_0000, 32'd1);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL slt_ready got %b exp 1", bus.req0_ready); end
    tick();
    set_req0(1'b0, 4'h0, '0, '0);
    checks++; if (alu_ctrl !== 4'b0111 || alu_a !== 32'h8000_0000 || alu_b !== 32'd1)
      begin errors++; $display("FAIL slt_exec got %b %h %h exp 0111 80000000 1", alu_ctrl, alu_a, alu_b); end
    tick();
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd1 || bus.rsp0_err !== 1'b0)
      begin errors++; $display("FAIL slt_rsp got v=%b r=%h e=%b exp 1 1 0", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err); end
    checks++; if (alu_a !== 32'h8000_0000) begin errors++; $display("FAIL slt_hold_a got %h exp 80000000", alu_a); end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal_ctrl();
    test_backpressure();
    test_reset_mid_exec();
    test_slt_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the main execute path (port 0) and a branch-compare/address unit (port 1).
- Arbitrates round-robin and drives the ALU from captured operands.
- Returns the registered result to the winning requester over a valid/ready response channel.
- Only one operation is in flight at any time.

Parameters:
- XLEN, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 has an operation.
- req0_ready  output  1  port 0 operation accepted this cycle.
- req0_ctrl  input  4  port 0 ALU control code.
- req0_a  input  XLEN  port 0 operand A.
- req0_b  input  XLEN  port 0 operand B.
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b: same directions and widths as port 0, for port 1.
- rsp0_valid  output  1  port 0 result available.
- rsp0_ready  input  1  port 0 consumes result.
- rsp0_result  output  XLEN  port 0 result.
- rsp0_err  output  1  port 0 control code was not a legal ALU code.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_err: same as port 0, for port 1.
- alu_ctrl  output  4  to shared ALU.
- alu_a  output  XLEN  to shared ALU.
- alu_b  output  XLEN  to shared ALU.
- alu_result  input  XLEN  from shared ALU (combinational).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All captured registers = 0.
  - rsp*_valid=0, rsp*_err=0, rsp*_result=0.
  - alu_ctrl=4'b1111, alu_a=alu_b=0, busy=0.
  - An operation in progress is discarded; no response is produced for it.
- Grant logic (combinational, IDLE only):
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - reqN_ready = (state==IDLE) && (grant==N). reqN_ready may depend on reqN_valid.
  - A port never sees ready outside IDLE.
- Accept (IDLE, valid&&ready on granted port N):
  - Capture ctrl, a, b and owner=N.
  - last_grant<=N; state<=EXEC.
- EXEC (exactly 1 cycle):
  - alu_ctrl=captured ctrl; alu_a/alu_b=captured operands.
  - Capture alu_result into the owner's result register.
  - Set err=1 if ctrl is not in {0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT}; illegal codes still drive the ALU and their result is returned unchanged.
  - state<=RESP.
- Outside EXEC: alu_ctrl=4'b1111; alu_a/alu_b hold their captured values.
- RESP:
  - rsp<owner>_valid=1 with result and err held stable until rsp<owner>_ready=1.
  - On the handshake: valid drops next cycle, state<=IDLE.
  - The non-owner's rsp*_valid stays 0.
- Latency: accept at edge N, result captured at edge N+1, rsp_valid high from edge N+1, at most 1 cycle after alu_result is sampled.
  - Minimum accept-to-accept spacing is 3 cycles when the response is consumed immediately.
- New requests arriving during EXEC/RESP wait (ready=0); request inputs may change freely while not accepted.
- Simultaneous events:
  - A response handshake and a new request in the same RESP cycle: the request is not accepted until the following IDLE cycle.
  - A pending request from the other port then wins by round-robin.
- Width: all data is XLEN bits with no extension; the err bit is independent of the result.

Test Plan:
- Reset then req0 only, ctrl=0010, a=5, b=7 -> req0_ready=1 at accept; alu_ctrl=0010 next cycle; rsp0_valid=1, rsp0_result=12, rsp0_err=0; rsp1_valid stays 0.
- Both ports valid continuously (port0 SUB 10-3, port1 AND 0xF0&0x3C), rsp*_ready=1 -> grant order 0,1,0,1; results 7 and 0x30 alternate; accept spacing is 3 cycles.
- req1 ctrl=4'b1111, a=1, b=1 -> rsp1_valid=1, rsp1_err=1; result equals whatever the ALU returned for 1111.
- Response backpressure: rsp0_ready=0 for 5 cycles with req1 valid -> req1_ready=0 throughout; rsp0_result stable; req1 accepted the cycle after the rsp0 handshake.
- Assert rst_n=0 asynchronously mid-EXEC -> busy=0, rsp*_valid=0 and alu_ctrl=1111 immediately; after release, both ports valid -> port 0 granted first.
- SLT signed edge case: port0 ctrl=0111, a=0x80000000, b=1 -> rsp0_result equals alu_result (1 for a signed-compare ALU); alu_a/alu_b match the captured operands during EXEC.
